// File: rtl/pet_pkg.sv
// Shared definitions for the PET transmit framing path: state encoding,
// framing byte constants and CRC-32 constants used by transmit and receive.
package pet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_DATA = 3'd3,
        ST_PAD  = 3'd4,
        ST_FCS  = 3'd5,
        ST_IFG  = 3'd6
    } pet_state_e;

    localparam logic [7:0]  PET_PREAMBLE    = 8'h55;
    localparam logic [7:0]  PET_SFD         = 8'hD5;
    localparam logic [31:0] PET_CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] PET_CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] PET_CRC_RESIDUE = 32'hC704DD7B;

    // Width of the saturating per-frame byte counter
    localparam int PET_CNT_W = 11;

    // Bit-reverse a 32-bit word; turns the normal polynomial into the
    // form used by the LSB-first (reflected) CRC engine
    function automatic logic [31:0] pet_reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/petcrc32_d8.sv
// Combinational IEEE 802.3 CRC-32 step: advances a reflected CRC register
// by one byte, LSB first. Shared by the transmit FCS generator and the
// receive checker.
module petcrc32_d8
    import pet_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REFL = pet_reflect32(PET_CRC_POLY);

    // Eight serial shift/XOR steps unrolled into one byte-wide update
    always_comb begin
        logic [31:0] c;
        c = crc_in ^ {24'h000000, data_in};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/pettx_padfcs.sv
// Transmit framing stage: adds preamble/SFD, pads short frames, appends the
// FCS and enforces the inter-frame gap on the byte-wide GMII/MII side.
// Everything advances only on tx_ce so the same logic serves 10/100/1000.
module pettx_padfcs
    import pet_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12
) (
    input  logic       tx_clk,
    input  logic       tx_rst_n,
    input  logic       tx_ce,
    input  logic       pad_en,
    input  logic       crc_en,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic       in_eof,
    output logic       in_ready,
    output logic [7:0] txd,
    output logic       tx_en,
    output logic       tx_er,
    output logic       underrun,
    output logic       busy
);

    localparam logic [15:0]          PRE_LAST = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0]          IFG_LAST = 16'(IFG_BYTES - 1);
    localparam logic [PET_CNT_W-1:0] MIN_CNT  = PET_CNT_W'(MIN_FRAME);
    localparam logic [PET_CNT_W-1:0] CNT_MAX  = '1;

    pet_state_e           state_q, state_d;
    logic [15:0]          sub_q, sub_d;
    logic [PET_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]          crc_q, crc_d;
    logic                 pad_on_q, pad_on_d;
    logic                 crc_on_q, crc_on_d;
    logic [7:0]           txd_q, txd_d;
    logic                 tx_en_q, tx_en_d;
    logic                 tx_er_q, tx_er_d;
    logic                 underrun_q, underrun_d;

    logic [7:0]           crc_data;
    logic [31:0]          crc_next;
    logic [PET_CNT_W-1:0] cnt_inc;
    logic [31:0]          fcs_word;
    logic [7:0]           fcs_byte;

    // Pad bytes feed zeros into the CRC; otherwise the incoming byte does
    assign crc_data = (state_q == ST_PAD) ? 8'h00 : in_data;
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign fcs_word = ~crc_q;
    assign fcs_byte = fcs_word[{sub_q[1:0], 3'b000} +: 8];

    petcrc32_d8 u_crc (
        .crc_in  (crc_q),
        .data_in (crc_data),
        .crc_out (crc_next)
    );

    // Next-state and next-output logic; everything holds when tx_ce is low
    always_comb begin
        state_d    = state_q;
        sub_d      = sub_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        pad_on_d   = pad_on_q;
        crc_on_d   = crc_on_q;
        txd_d      = txd_q;
        tx_en_d    = tx_en_q;
        tx_er_d    = tx_er_q;
        underrun_d = underrun_q;
        if (tx_ce) begin
            txd_d      = 8'h00;
            tx_en_d    = 1'b0;
            tx_er_d    = 1'b0;
            underrun_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_sof) begin
                        pad_on_d = pad_en;
                        crc_on_d = crc_en;
                        cnt_d    = '0;
                        crc_d    = PET_CRC_INIT;
                        sub_d    = '0;
                        state_d  = ST_PRE;
                    end
                end
                ST_PRE: begin
                    txd_d   = PET_PREAMBLE;
                    tx_en_d = 1'b1;
                    if (sub_q == PRE_LAST) begin
                        sub_d   = '0;
                        state_d = ST_SFD;
                    end else begin
                        sub_d = sub_q + 16'd1;
                    end
                end
                ST_SFD: begin
                    txd_d   = PET_SFD;
                    tx_en_d = 1'b1;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    // The opening byte legitimately carries SOF (it was
                    // only peeked in IDLE); a later SOF means a lost EOF
                    if (!in_valid || (in_sof && cnt_q != '0)) begin
                        tx_en_d    = 1'b1;
                        tx_er_d    = 1'b1;
                        underrun_d = 1'b1;
                        sub_d      = '0;
                        state_d    = ST_IFG;
                    end else begin
                        txd_d   = in_data;
                        tx_en_d = 1'b1;
                        crc_d   = crc_next;
                        cnt_d   = cnt_inc;
                        if (in_eof) begin
                            sub_d = '0;
                            if (pad_on_q && cnt_inc < MIN_CNT) begin
                                state_d = ST_PAD;
                            end else if (crc_on_q) begin
                                state_d = ST_FCS;
                            end else begin
                                state_d = ST_IFG;
                            end
                        end
                    end
                end
                ST_PAD: begin
                    tx_en_d = 1'b1;
                    crc_d   = crc_next;
                    cnt_d   = cnt_inc;
                    if (cnt_inc >= MIN_CNT) begin
                        sub_d   = '0;
                        state_d = crc_on_q ? ST_FCS : ST_IFG;
                    end
                end
                ST_FCS: begin
                    txd_d   = fcs_byte;
                    tx_en_d = 1'b1;
                    if (sub_q[1:0] == 2'd3) begin
                        sub_d   = '0;
                        state_d = ST_IFG;
                    end else begin
                        sub_d = sub_q + 16'd1;
                    end
                end
                ST_IFG: begin
                    if (sub_q == IFG_LAST) begin
                        sub_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        sub_d = sub_q + 16'd1;
                    end
                end
                default: begin
                    sub_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state_q    <= ST_IDLE;
            sub_q      <= '0;
            cnt_q      <= '0;
            crc_q      <= PET_CRC_INIT;
            pad_on_q   <= 1'b0;
            crc_on_q   <= 1'b0;
            txd_q      <= 8'h00;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sub_q      <= sub_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            pad_on_q   <= pad_on_d;
            crc_on_q   <= crc_on_d;
            txd_q      <= txd_d;
            tx_en_q    <= tx_en_d;
            tx_er_q    <= tx_er_d;
            underrun_q <= underrun_d;
        end
    end

    assign in_ready = (state_q == ST_DATA);
    assign busy     = (state_q != ST_IDLE);
    assign txd      = txd_q;
    assign tx_en    = tx_en_q;
    assign tx_er    = tx_er_q;
    assign underrun = underrun_q;

endmodule
